// File: rtl/adder32_cla.sv
// -----------------------------------------------------------------------------
// adder32_cla
//
// 32-bit two's-complement adder for PC increment and address/branch-target
// arithmetic. The sum and its flags are purely combinational, so a PC register
// can load PC + 4 in the same cycle. A registered copy of the sum and flags is
// also provided for downstream pipeline stages.
//
// The carry chain is a two-level carry-lookahead structure: eight 4-bit
// lookahead groups, plus a second-level unit that computes the carry into
// each group from the group generate/propagate terms and Cin.
//
// Ports
//   CLK      in   1   rising-edge clock (registered outputs only)
//   RST      in   1   synchronous active-high reset (registered outputs only)
//   A        in  32   operand A
//   B        in  32   operand B
//   Cin      in   1   carry-in (tie to 0 for a plain add)
//   En       in   1   capture enable for the registered outputs
//   OUT      out 32   combinational sum (A + B + Cin) mod 2^32
//   Cout     out  1   combinational carry out of bit 31
//   Ovf      out  1   combinational signed overflow
//   Zero     out  1   combinational flag, 1 when OUT == 0
//   OUT_Q    out 32   registered OUT
//   Flags_Q  out  3   registered {Cout, Ovf, Zero}
// -----------------------------------------------------------------------------
module adder32_cla #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             En,
  output logic [WIDTH-1:0] OUT,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic [WIDTH-1:0] OUT_Q,
  output logic [2:0]       Flags_Q
);

  localparam int NGROUPS = WIDTH / GROUP;

  // Per-bit generate / propagate and the carry into every bit position.
  logic [WIDTH-1:0]   g;
  logic [WIDTH-1:0]   p;
  logic [WIDTH-1:0]   c;

  // Group generate / propagate and the carry into each group.
  logic [NGROUPS-1:0] grp_g;
  logic [NGROUPS-1:0] grp_p;
  logic [NGROUPS-1:0] grp_c;

  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               ovf;
  logic               zero;

  assign g = A & B;
  assign p = A ^ B;

  // ---------------------------------------------------------------------------
  // First level: 4-bit lookahead groups. Each internal carry is a flat
  // sum-of-products of the group's g/p bits and the group carry-in, so no carry
  // ripples bit to bit inside a group.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
    localparam int B0 = k * GROUP;

    assign c[B0]   = grp_c[k];
    assign c[B0+1] = g[B0]
                   | (p[B0] & grp_c[k]);
    assign c[B0+2] = g[B0+1]
                   | (p[B0+1] & g[B0])
                   | (p[B0+1] & p[B0] & grp_c[k]);
    assign c[B0+3] = g[B0+2]
                   | (p[B0+2] & g[B0+1])
                   | (p[B0+2] & p[B0+1] & g[B0])
                   | (p[B0+2] & p[B0+1] & p[B0] & grp_c[k]);

    assign grp_g[k] = g[B0+3]
                    | (p[B0+3] & g[B0+2])
                    | (p[B0+3] & p[B0+2] & g[B0+1])
                    | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
    assign grp_p[k] = p[B0+3] & p[B0+2] & p[B0+1] & p[B0];
  end

  // ---------------------------------------------------------------------------
  // Second level: carry into group k expanded as
  //   OR_{j<k} ( grp_g[j] & AND_{j<m<k} grp_p[m] )  |  ( AND_{m<k} grp_p[m] & Cin )
  // The loops only unroll into that two-level AND-OR form; nothing here
  // depends on a previously computed group carry.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic term;
    logic acc;
    grp_c    = '0;
    grp_c[0] = Cin;
    term     = 1'b0;
    acc      = 1'b0;
    for (int k = 1; k < NGROUPS; k++) begin
      term = Cin;
      for (int m = 0; m < k; m++) begin
        term = term & grp_p[m];
      end
      acc = term;
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      grp_c[k] = acc;
    end
  end

  assign sum  = p ^ c;
  assign cout = grp_g[NGROUPS-1] | (grp_p[NGROUPS-1] & grp_c[NGROUPS-1]);
  assign ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  assign zero = ~|sum;

  assign OUT  = sum;
  assign Cout = cout;
  assign Ovf  = ovf;
  assign Zero = zero;

  // ---------------------------------------------------------------------------
  // Registered copy. The enable mux lives in the next-state logic; reset is
  // applied in the flop process and therefore overrides En.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic [2:0]       flags_d;
  logic [2:0]       flags_q;

  always_comb begin
    out_d   = out_q;
    flags_d = flags_q;
    if (En) begin
      out_d   = sum;
      flags_d = {cout, ovf, zero};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q   <= '0;
      flags_q <= 3'b000;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign OUT_Q   = out_q;
  assign Flags_Q = flags_q;

endmodule

// File: tb/tb_adder32_cla.sv
// -----------------------------------------------------------------------------
// tb_adder32_cla
//
// Directed-vector bench for adder32_cla. Combinational outputs are checked
// #1 after inputs change (on the falling edge); registered outputs are checked
// #1 after the rising edge that captures them.
// -----------------------------------------------------------------------------
module tb_adder32_cla;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic        cin = 1'b0;
  logic        en  = 1'b0;

  logic [31:0] out;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic [31:0] out_q;
  logic [2:0]  flags_q;

  always #5 clk = ~clk;

  adder32_cla dut (
    .CLK     (clk),
    .RST     (rst),
    .A       (a),
    .B       (b),
    .Cin     (cin),
    .En      (en),
    .OUT     (out),
    .Cout    (cout),
    .Ovf     (ovf),
    .Zero    (zero),
    .OUT_Q   (out_q),
    .Flags_Q (flags_q)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: a, b, cin -> out, cout, ovf, zero (hand computed)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] out;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_03FC, 32'h0000_0004, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFC, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'h00FF_00FF, 32'h0000_FF01, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0});
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic vcin, input logic ven, input logic vrst);
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vcin;
    en  = ven;
    rst = vrst;
    #1;
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [32:0] ref_sum;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        ref_ovf;

    // Reset state.
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step_edge();
    check("rst_out_q", {1'b0, out_q}, 33'h0);
    check("rst_flags_q", {30'h0, flags_q}, 33'h0);

    // Combinational path is live during reset; reset beats En.
    drive(32'hFFFF_FFFC, 32'h4, 1'b0, 1'b1, 1'b1);
    check("rst_comb_out", {1'b0, out}, 33'h0);
    check("rst_comb_flags", {30'h0, cout, ovf, zero}, 33'h5);
    step_edge();
    check("rst_prio_out_q", {1'b0, out_q}, 33'h0);
    check("rst_prio_flags_q", {30'h0, flags_q}, 33'h0);

    // Directed vectors: combinational same cycle, registered one edge later.
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, 1'b0);
      check($sformatf("v%0d_out", i), {1'b0, out}, {1'b0, vecs[i].out});
      check($sformatf("v%0d_flags", i), {30'h0, cout, ovf, zero},
            {30'h0, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
      step_edge();
      check($sformatf("v%0d_out_q", i), {1'b0, out_q}, {1'b0, vecs[i].out});
      check($sformatf("v%0d_flags_q", i), {30'h0, flags_q},
            {30'h0, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
    end

    // Register path: capture, hold with En=0, then reset with En=1.
    drive(32'h10, 32'h20, 1'b0, 1'b1, 1'b0);
    step_edge();
    check("reg_cap_out_q", {1'b0, out_q}, 33'h30);
    check("reg_cap_flags_q", {30'h0, flags_q}, 33'h0);

    drive(32'h100, 32'h20, 1'b0, 1'b0, 1'b0);
    check("hold_comb_out", {1'b0, out}, 33'h120);
    step_edge();
    check("hold_out_q", {1'b0, out_q}, 33'h30);

    drive(32'hFFFF_FFFC, 32'h4, 1'b0, 1'b0, 1'b0);
    step_edge();
    check("hold2_out_q", {1'b0, out_q}, 33'h30);
    check("hold2_flags_q", {30'h0, flags_q}, 33'h0);
    check("hold2_comb_flags", {30'h0, cout, ovf, zero}, 33'h5);

    drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
    step_edge();
    check("pre_rst_out_q", {1'b0, out_q}, 33'h8000_0000);
    check("pre_rst_flags_q", {30'h0, flags_q}, 33'h2);

    drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1);
    check("mid_rst_comb_out", {1'b0, out}, 33'h8000_0000);
    step_edge();
    check("mid_rst_out_q", {1'b0, out_q}, 33'h0);
    check("mid_rst_flags_q", {30'h0, flags_q}, 33'h0);
    check("mid_rst_comb_ovf", {32'h0, ovf}, 33'h1);

    // Random vectors against a 33-bit reference sum and the flag equations.
    for (int n = 0; n < 300; n++) begin
      ra = {$urandom_range(16'hFFFF, 0), $urandom_range(16'hFFFF, 0)} & 32'hFFFF_FFFF;
      rb = {$urandom_range(16'hFFFF, 0), $urandom_range(16'hFFFF, 0)} & 32'hFFFF_FFFF;
      rc = 1'($urandom_range(1, 0));
      ref_sum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      ref_ovf = (ra[31] == rb[31]) && (ref_sum[31] != ra[31]);
      drive(ra, rb, rc, 1'b1, 1'b0);
      check("rnd_sum", {cout, out}, ref_sum);
      check("rnd_ovf_zero", {31'h0, ovf, zero}, {31'h0, ref_ovf, (ref_sum[31:0] == 32'h0)});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
